universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised universal shift register: the successor to the single-bit left/right shifter. Adds parallel load, logical, arithmetic and rotate shifts by a runtime amount, and an autonomous burst mode that repeats one operation a programmed number of times with busy/done status. Used as a generic datapath primitive: serialisers, bit-field alignment, LFSR-style test patterns.

## Interface
- WIDTH, 8, register width; must be ≥ 2
- CNT_W, 8, width of the burst-count input
- AMT_W, $clog2(WIDTH), derived, width of the shift amount
- clk_i  in  1  clock; all logic is on its rising edge
- rst_i  in  1  reset; one clock, reset is synchronous and active-high
- en_i  in  1  global enable; when low all state freezes, including the burst counter
- op_i  in  3  operation code (see Operation)
- amt_i  in  AMT_W  shift/rotate distance per operation; 0 = no movement
- sdi_i  in  1  serial fill bit for logical shifts, replicated into every vacated position
- pdata_i  in  WIDTH  parallel load data
- start_i  in  1  start burst; sampled only when idle and en_i=1
- cnt_i  in  CNT_W  number of operations in the burst
- data_o  out  WIDTH  register contents
- msb_o / lsb_o  out  1  data_o[WIDTH-1] and data_o[0]
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse when a burst finishes

## Operation
- Op codes: 0 HOLD, 1 LOAD (data ← pdata_i), 2 SHL (logical left by amt, fill sdi_i), 3 SHR (logical right, fill sdi_i), 4 ASR (arithmetic right, fill old MSB), 5 ROL, 6 ROR, 7 CLR (data ← 0).
- amt_i ≥ WIDTH is impossible by width, except when WIDTH is not a power of two. In that case, amt ≥ WIDTH on SHL/SHR fills the whole register with sdi_i, ASR fills it with the old MSB, and ROL/ROR use amt mod WIDTH.
- States: IDLE, BURST.
- IDLE behaviour:
  - With en_i=1 and start_i=0, op_i is applied to data_o each cycle.
  - With en_i=1 and start_i=1, op_i and amt_i are latched, the counter is loaded with cnt_i, and the FSM goes to BURST. No data operation occurs in the start cycle.
- BURST behaviour:
  - Each cycle with en_i=1, the latched op is applied and the counter decrements.
  - When the counter reaches 0, the FSM returns to IDLE and done_o pulses.
  - op_i, amt_i and start_i are ignored.
- cnt_i=0: BURST is entered, then exits next enabled cycle with done_o and no data change.
- en_i=0 in any state: nothing changes, done_o stays 0, and a pending done is deferred to the next enabled cycle.
- Reset: data_o=0, FSM=IDLE, counter=0, busy_o=0, done_o=0, latched op=HOLD. Reset mid-burst aborts it with no done_o.

## Timing
- All outputs are registered.
- Manual op: result visible on data_o one cycle after the enabled edge.
- Burst of N (N ≥ 1):
  - Start edge T: busy_o=1 from T+1.
  - Operations occur at edges T+1..T+N (enabled cycles only).
  - busy_o falls and done_o=1 for the cycle after edge T+N.
  - Earliest next start is sampled in that same done cycle.
- done_o and busy_o are never high together.

## Configuration
- SHREG_ROTATE_EN is defined: ROL/ROR are implemented as above.
- SHREG_ROTATE_EN is not defined:
  - Op codes 5 and 6 act as HOLD, in manual and burst mode alike.
  - The burst counter still runs.
  - The rotate datapath is not synthesised.

## Structure
- Package universal_shift_reg_pkg holds:
  - op enum shreg_op_e (HOLD..CLR, 3-bit)
  - FSM state enum shreg_state_e
- Sub-module shreg_core: combinational next-data function (op, amt, sdi, pdata, data) → next data. The top level keeps the FSM, the counter and the registers.

## Test plan
- Reset then LOAD 8'hA5 → data_o=8'hA5 next cycle. SHL amt=1 sdi=1 → 8'h4B.
- data=8'h96: ASR amt=2 → 8'hE5. SHR amt=2 sdi=0 from 8'h96 → 8'h25.
- With SHREG_ROTATE_EN, data=8'h81, ROL amt=1 → 8'h03. Without the macro, same stimulus → 8'h81 unchanged.
- Burst ROR amt=1 cnt=8 on 8'h3C:
  - busy_o high 8 cycles.
  - done_o pulses once.
  - data_o returns to 8'h3C.
- Burst SHL cnt=4 with en_i low for 3 cycles mid-burst → done_o delayed exactly 3 cycles. start_i during busy is ignored.
- Edge cases:
  - cnt=0 burst: busy_o high one cycle, then done_o, with data unchanged.
  - rst_i asserted mid-burst: all outputs 0 next cycle, no done_o.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package universal_shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ASR  = 3'd4,
      OP_ROL  = 3'd5,
      OP_ROR  = 3'd6,
      OP_CLR  = 3'd7
   } shreg_op_e;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } shreg_state_e;

endpackage

// File: rtl/shreg_core.sv
// Next-data function of the shift register: applies one op to the current contents.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether the result is registered.
//
// Ports: op/amt/sdi/pdata select and parameterise the operation, data is the
// current register value, next_data is the result.
// Macro SHREG_ROTATE_EN: when undefined, ROL/ROR behave as HOLD and no rotate
// logic is built.
module shreg_core
   import universal_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  shreg_op_e        op,
   input  logic [AMT_W-1:0] amt,
   input  logic             sdi,
   input  logic [WIDTH-1:0] pdata,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] next_data
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] shl_fill;
   logic [WIDTH-1:0] shr_fill;
   logic [WIDTH-1:0] asr_data;

   // Vacated-position masks. A shift by >= WIDTH (only reachable when WIDTH is
   // not a power of two) shifts ONES out entirely, so the mask covers the whole
   // register and the result is all sdi, as intended.
   always_comb begin
      shl_fill = sdi ? ~(ONES << amt) : '0;
      shr_fill = sdi ? ~(ONES >> amt) : '0;
      asr_data = $unsigned($signed(data) >>> amt);
   end

`ifdef SHREG_ROTATE_EN
   localparam logic [AMT_W:0] WIDTH_L = (AMT_W+1)'(WIDTH);

   logic [AMT_W:0]   rot_amt;
   logic [AMT_W:0]   rot_inv;
   logic [WIDTH-1:0] rol_data;
   logic [WIDTH-1:0] ror_data;

   // rot_amt = 0 gives rot_inv = WIDTH, whose shift yields 0, so the OR
   // degenerates cleanly to the unrotated value.
   always_comb begin
      rot_amt  = {1'b0, amt} % WIDTH_L;
      rot_inv  = WIDTH_L - rot_amt;
      rol_data = (data << rot_amt) | (data >> rot_inv);
      ror_data = (data >> rot_amt) | (data << rot_inv);
   end
`endif

   always_comb begin
      next_data = data;
      case (op)
         OP_LOAD: next_data = pdata;
         OP_SHL:  next_data = (data << amt) | shl_fill;
         OP_SHR:  next_data = (data >> amt) | shr_fill;
         OP_ASR:  next_data = asr_data;
`ifdef SHREG_ROTATE_EN
         OP_ROL:  next_data = rol_data;
         OP_ROR:  next_data = ror_data;
`endif
         OP_CLR:  next_data = '0;
         default: next_data = data;
      endcase
   end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with manual ops and a counted burst mode (busy/done).
// Latency: manual op result on data_o 1 cycle after the enabled edge; all outputs registered.
// Backpressure: en_i low freezes everything, burst counter and pending done included.
//
// Ports: clk_i, rst_i (sync, active-high), en_i, op_i, amt_i, sdi_i, pdata_i,
// start_i, cnt_i in; data_o, msb_o, lsb_o, busy_o, done_o out.
// Macro SHREG_ROTATE_EN enables ROL/ROR; otherwise they act as HOLD.
module universal_shift_reg
   import universal_shift_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int CNT_W = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [2:0]       op_i,
   input  logic [AMT_W-1:0] amt_i,
   input  logic             sdi_i,
   input  logic [WIDTH-1:0] pdata_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic [WIDTH-1:0] data_o,
   output logic             msb_o,
   output logic             lsb_o,
   output logic             busy_o,
   output logic             done_o
);

   shreg_state_e     state_q;
   shreg_op_e        op_q;
   logic [AMT_W-1:0] amt_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             done_q;

   shreg_op_e        op_sel;
   logic [AMT_W-1:0] amt_sel;
   logic [WIDTH-1:0] core_data;

   // In a burst the latched op/amt drive the datapath; live inputs are ignored.
   always_comb begin
      op_sel  = shreg_op_e'(op_i);
      amt_sel = amt_i;
      if (state_q == ST_BURST) begin
         op_sel  = op_q;
         amt_sel = amt_q;
      end
   end

   shreg_core #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_core (
      .op        (op_sel),
      .amt       (amt_sel),
      .sdi       (sdi_i),
      .pdata     (pdata_i),
      .data      (data_q),
      .next_data (core_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_HOLD;
         amt_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else if (en_i) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  // Start cycle only latches; the first op lands on the next edge.
                  op_q    <= shreg_op_e'(op_i);
                  amt_q   <= amt_i;
                  cnt_q   <= cnt_i;
                  state_q <= ST_BURST;
               end else begin
                  data_q <= core_data;
               end
            end
            ST_BURST: begin
               if (cnt_q == '0) begin
                  // Zero-length burst: leave without touching the data.
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  data_q <= core_data;
                  cnt_q  <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= ST_IDLE;
                     done_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end else begin
         // Frozen cycle: a done that has not yet been raised waits for the
         // next enabled edge, and a raised one is not stretched.
         done_q <= 1'b0;
      end
   end

   always_comb begin
      data_o = data_q;
      msb_o  = data_q[WIDTH-1];
      lsb_o  = data_q[0];
      busy_o = (state_q == ST_BURST);
      done_o = done_q;
   end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=8, CNT_W=8).
// Latency: n/a.
// Backpressure: exercised by dropping en_i inside a burst.
module tb_universal_shift_reg;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic [2:0] op_i;
   logic [2:0] amt_i;
   logic       sdi_i;
   logic [7:0] pdata_i;
   logic       start_i;
   logic [7:0] cnt_i;
   logic [7:0] data_o;
   logic       msb_o;
   logic       lsb_o;
   logic       busy_o;
   logic       done_o;

   int n_cmp = 0;
   int n_bad = 0;

   universal_shift_reg #(
      .WIDTH (8),
      .CNT_W (8)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (en_i),
      .op_i    (op_i),
      .amt_i   (amt_i),
      .sdi_i   (sdi_i),
      .pdata_i (pdata_i),
      .start_i (start_i),
      .cnt_i   (cnt_i),
      .data_o  (data_o),
      .msb_o   (msb_o),
      .lsb_o   (lsb_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled and new inputs driven 1ns later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_op(input logic [2:0] op, input logic [2:0] amt, input logic sdi,
                        input logic [7:0] pd);
      op_i = op; amt_i = amt; sdi_i = sdi; pdata_i = pd;
      step();
   endtask

   initial begin : stim
      int busy_cycles;
      int done_cycles;
      int both_high;
      int done_at;
      logic [7:0] rot_exp;

      rst_i = 1'b1; en_i = 1'b1; op_i = 3'd0; amt_i = 3'd0; sdi_i = 1'b0;
      pdata_i = 8'h00; start_i = 1'b0; cnt_i = 8'd0;
      step();
      step();
      check("rst_data", data_o, 8'h00);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      rst_i = 1'b0;

      // Manual operations
      do_op(3'd1, 3'd0, 1'b0, 8'hA5);
      check("load_a5", data_o, 8'hA5);
      check("load_msb", msb_o, 1'b1);
      check("load_lsb", lsb_o, 1'b1);
      do_op(3'd2, 3'd1, 1'b1, 8'h00);
      check("shl1_sdi1", data_o, 8'h4B);
      do_op(3'd1, 3'd0, 1'b0, 8'h96);
      do_op(3'd4, 3'd2, 1'b0, 8'h00);
      check("asr2", data_o, 8'hE5);
      do_op(3'd1, 3'd0, 1'b0, 8'h96);
      do_op(3'd3, 3'd2, 1'b0, 8'h00);
      check("shr2_sdi0", data_o, 8'h25);
      check("shr2_msb", msb_o, 1'b0);
      do_op(3'd3, 3'd3, 1'b1, 8'h00);
      check("shr3_sdi1", data_o, 8'hE4);
      do_op(3'd2, 3'd0, 1'b1, 8'h00);
      check("shl0_nomove", data_o, 8'hE4);
      en_i = 1'b0;
      do_op(3'd7, 3'd0, 1'b0, 8'h00);
      check("en0_freeze", data_o, 8'hE4);
      en_i = 1'b1;
      do_op(3'd7, 3'd0, 1'b0, 8'h00);
      check("clr", data_o, 8'h00);
      do_op(3'd1, 3'd0, 1'b0, 8'h5A);
      do_op(3'd0, 3'd5, 1'b1, 8'hFF);
      check("hold", data_o, 8'h5A);

      do_op(3'd1, 3'd0, 1'b0, 8'h81);
      do_op(3'd5, 3'd1, 1'b0, 8'h00);
`ifdef SHREG_ROTATE_EN
      rot_exp = 8'h03;
`else
      rot_exp = 8'h81;
`endif
      check("rol1", data_o, rot_exp);
      do_op(3'd1, 3'd0, 1'b0, 8'h3C);
      do_op(3'd6, 3'd3, 1'b0, 8'h00);
`ifdef SHREG_ROTATE_EN
      rot_exp = 8'h87;
`else
      rot_exp = 8'h3C;
`endif
      check("ror3", data_o, rot_exp);

      // Burst ROR amt=1 cnt=8 on 3C
      do_op(3'd1, 3'd0, 1'b0, 8'h3C);
      op_i = 3'd6; amt_i = 3'd1; cnt_i = 8'd8; start_i = 1'b1;
      step();
      check("ror_b_start_busy", busy_o, 1'b1);
      check("ror_b_start_data", data_o, 8'h3C);
      start_i = 1'b0; op_i = 3'd0; amt_i = 3'd0;
      busy_cycles = 0; done_cycles = 0; both_high = 0;
      for (int i = 0; i < 12; i++) begin
         if (busy_o) busy_cycles++;
         if (done_o) done_cycles++;
         if (busy_o && done_o) both_high++;
         step();
         if (i == 0) begin
`ifdef SHREG_ROTATE_EN
            rot_exp = 8'h1E;
`else
            rot_exp = 8'h3C;
`endif
            check("ror_b_first", data_o, rot_exp);
         end
      end
      check("ror_b_busy_cycles", busy_cycles, 8);
      check("ror_b_done_pulses", done_cycles, 1);
      check("ror_b_overlap", both_high, 0);
      check("ror_b_data", data_o, 8'h3C);

      // Burst SHL cnt=4 with a 3-cycle en_i gap; start/op/amt driven mid-burst are ignored
      do_op(3'd1, 3'd0, 1'b0, 8'h01);
      op_i = 3'd2; amt_i = 3'd1; sdi_i = 1'b0; cnt_i = 8'd4; start_i = 1'b1;
      step();
      op_i = 3'd7; amt_i = 3'd3; cnt_i = 8'd9;
      done_at = 0;
      for (int k = 1; k <= 20; k++) begin
         en_i = !(k >= 2 && k <= 4);
         start_i = (k <= 5);
         step();
         if (k == 1) check("shl_b_op1", data_o, 8'h02);
         if (k == 4) check("shl_b_frozen", data_o, 8'h02);
         if (done_o) begin
            done_at = k;
            break;
         end
      end
      en_i = 1'b1; start_i = 1'b0;
      check("shl_b_done_edge", done_at, 7);
      check("shl_b_data", data_o, 8'h10);
      check("shl_b_busy_at_done", busy_o, 1'b0);
      op_i = 3'd0;
      step();
      check("shl_b_done_once", done_o, 1'b0);
      check("shl_b_idle", busy_o, 1'b0);

      // Zero-length burst
      do_op(3'd1, 3'd0, 1'b0, 8'h77);
      op_i = 3'd2; amt_i = 3'd1; sdi_i = 1'b1; cnt_i = 8'd0; start_i = 1'b1;
      step();
      start_i = 1'b0; op_i = 3'd0;
      check("cnt0_busy", busy_o, 1'b1);
      check("cnt0_nodone", done_o, 1'b0);
      step();
      check("cnt0_done", done_o, 1'b1);
      check("cnt0_busy_low", busy_o, 1'b0);
      check("cnt0_data", data_o, 8'h77);
      step();
      check("cnt0_done_clr", done_o, 1'b0);

      // Reset mid-burst
      do_op(3'd1, 3'd0, 1'b0, 8'h0F);
      op_i = 3'd2; amt_i = 3'd1; sdi_i = 1'b0; cnt_i = 8'd5; start_i = 1'b1;
      step();
      start_i = 1'b0; op_i = 3'd0;
      step();
      check("rstmid_op1", data_o, 8'h1E);
      rst_i = 1'b1;
      step();
      check("rstmid_data", data_o, 8'h00);
      check("rstmid_busy", busy_o, 1'b0);
      check("rstmid_done", done_o, 1'b0);
      rst_i = 1'b0;
      step();
      check("rstmid_no_done", done_o, 1'b0);
      check("rstmid_still_idle", busy_o, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
